key_gesture_decoder: RTL
========================

Name: key_gesture_decoder

Overview:
- Consumes the one-cycle press_down/press_up pulses from the key debouncer and classifies them into user gestures: single click, double click, long press, and auto-repeat while held.
- Sits between the per-key debouncer and the UI/control logic; one instance per key.
- Pure timing and state logic; all outputs are registered.

Parameters:
- LONG_CYC, 50_000_000, hold cycles from press to long_press (1 s at 50 MHz).
- DBL_CYC, 15_000_000, max release gap in cycles before a single click is committed (300 ms).
- REPEAT_CYC, 10_000_000, cycles between repeat pulses in the long-hold state (200 ms).
- CNT_W, 26, counter width; each *_CYC must be >= 2 and <= 2^CNT_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- press_down  in  1  one-cycle pulse, key became pressed (debounced)
- press_up  in  1  one-cycle pulse, key became released (debounced)
- click  out  1  one-cycle pulse, single click committed
- double_click  out  1  one-cycle pulse, second release of a double click
- long_press  out  1  one-cycle pulse, hold reached LONG_CYC
- repeat_tick  out  1  one-cycle pulse every REPEAT_CYC while long-held
- held  out  1  level, 1 while the FSM considers the key down

Behaviour:
- Reset (async): state=IDLE, cnt=0, all outputs 0. Reset mid-gesture discards any pending click; nothing is emitted afterwards.
- Single counter cnt (CNT_W bits):
  - Cleared on every state transition; increments by 1 each cycle otherwise.
  - A timeout of N fires on the clock edge where cnt==N-1 is sampled, i.e. N edges after state entry.
- The valid edge this cycle is ev_dn = press_down & ~press_up, or ev_up = press_up & ~press_down. Both asserted together counts as no event.
- States and transitions:
  - IDLE: ev_dn -> PRESS1. ev_up is ignored. cnt is held at 0.
  - PRESS1:
    - ev_up -> RELEASE1.
    - Otherwise LONG_CYC timeout -> LONG, with long_press pulse.
  - RELEASE1:
    - ev_dn -> PRESS2.
    - Otherwise DBL_CYC timeout -> IDLE, with click pulse.
  - PRESS2:
    - ev_up -> IDLE, with double_click pulse.
    - Otherwise LONG_CYC timeout -> LONG, with long_press pulse; the double click is discarded.
  - LONG:
    - ev_up -> IDLE, no pulse.
    - Otherwise REPEAT_CYC timeout -> repeat_tick pulse; cnt is cleared and the state stays in LONG.
  - Illegal encoding -> IDLE; outputs 0 the next cycle.
- Priority: an edge event always beats a timeout in the same cycle.
- Outputs:
  - Pulses are registered and appear one cycle after the triggering edge or timeout sample; each is exactly 1 cycle wide.
  - At most one pulse output is high in any cycle.
  - held = 1 in PRESS1, PRESS2 and LONG; registered, so it follows the state register.
- Extra ev_dn in PRESS*/LONG and extra ev_up in RELEASE1/IDLE are ignored, with no state or cnt change.
- The counter never wraps: every state with cnt running has a timeout that clears it before 2^CNT_W.

Decomposition:
- Shared package key_pkg:
  - state encoding localparams (IDLE, PRESS1, RELEASE1, PRESS2, LONG; 3 bits);
  - default cycle constants for the 50 MHz board;
  - the debouncer's 2 ms constant, so all key timing lives in one place.
- One sub-module, key_cycle_timer:
  - inputs clr and limit (CNT_W);
  - output done = (cnt==limit-1);
  - the FSM muxes limit by state.

Test Plan:
(bench overrides LONG_CYC=20, DBL_CYC=8, REPEAT_CYC=5)
- Single click: down at T0, up at T5 -> held high T1..T6; click high for exactly one cycle, 8 edges after the up edge plus 1 latency; no other pulses.
- Double click: down T0, up T5, down T8, up T12 -> double_click one cycle after the second up; click never asserts.
- Long press: down at T0, held 32 cycles, then up:
  - long_press one cycle after edge T20;
  - repeat_tick after T25 and after T30;
  - no pulse on release; held drops after the up edge.
- Edge/timeout collision: in RELEASE1, press_down arrives on the exact cycle cnt==7 -> enter PRESS2, no click; a later up gives double_click.
- Reset and abnormal input:
  - rst_n pulsed low for 2 cycles during RELEASE1 -> all outputs 0 immediately, no click afterwards; a following down/up yields a normal click.
  - press_up alone in IDLE, and press_down & press_up in the same cycle -> no state change, all outputs stay 0.

Source files
------------

// File: rtl/key_pkg.sv
// Shared key timing constants and gesture FSM state encoding.
// All key-related cycle counts for the 50 MHz board live here.
package key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS1   = 3'd1,
        ST_RELEASE1 = 3'd2,
        ST_PRESS2   = 3'd3,
        ST_LONG     = 3'd4
    } key_state_e;

    localparam int KEY_CNT_W        = 26;
    localparam int KEY_LONG_CYC     = 50_000_000;  // 1 s hold
    localparam int KEY_DBL_CYC      = 15_000_000;  // 300 ms release gap
    localparam int KEY_REPEAT_CYC   = 10_000_000;  // 200 ms repeat period
    localparam int KEY_DEBOUNCE_CYC = 100_000;     // 2 ms debouncer settle

endpackage

// File: rtl/key_cycle_timer.sv
// Free-running cycle counter with synchronous clear; done flags the last
// cycle of a limit-cycle interval.
module key_cycle_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;

    // Counter: cleared on request, otherwise counts up by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // A limit of 2^CNT_W truncates to zero, and zero minus one wraps to the max count.
    assign done = (cnt_r == (limit - CNT_ONE));

endmodule

// File: rtl/key_gesture_decoder.sv
// Classifies debounced press/release pulses into click, double click,
// long press and auto-repeat gestures; all outputs are registered.
module key_gesture_decoder
    import key_pkg::*;
#(
    parameter int LONG_CYC   = KEY_LONG_CYC,
    parameter int DBL_CYC    = KEY_DBL_CYC,
    parameter int REPEAT_CYC = KEY_REPEAT_CYC,
    parameter int CNT_W      = KEY_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic press_down,
    input  logic press_up,
    output logic click,
    output logic double_click,
    output logic long_press,
    output logic repeat_tick,
    output logic held
);

    localparam logic [CNT_W-1:0] LONG_LIM = LONG_CYC[CNT_W-1:0];
    localparam logic [CNT_W-1:0] DBL_LIM  = DBL_CYC[CNT_W-1:0];
    localparam logic [CNT_W-1:0] REP_LIM  = REPEAT_CYC[CNT_W-1:0];

    key_state_e       state_r;
    logic             click_r;
    logic             double_click_r;
    logic             long_press_r;
    logic             repeat_tick_r;
    logic             held_r;
    logic             ev_dn_s;
    logic             ev_up_s;
    logic             done_s;
    logic             clr_s;
    logic [CNT_W-1:0] limit_s;

    // Simultaneous press and release carry no information and are dropped.
    assign ev_dn_s = press_down & ~press_up;
    assign ev_up_s = press_up & ~press_down;

    // Timeout select and counter clear: clear on any state exit or repeat restart.
    always_comb begin
        limit_s = LONG_LIM;
        clr_s   = 1'b1;
        case (state_r)
            ST_IDLE: begin
                limit_s = LONG_LIM;
                clr_s   = 1'b1;
            end
            ST_PRESS1, ST_PRESS2: begin
                limit_s = LONG_LIM;
                clr_s   = ev_up_s | done_s;
            end
            ST_RELEASE1: begin
                limit_s = DBL_LIM;
                clr_s   = ev_dn_s | done_s;
            end
            ST_LONG: begin
                limit_s = REP_LIM;
                clr_s   = ev_up_s | done_s;
            end
            default: begin
                limit_s = LONG_LIM;
                clr_s   = 1'b1;
            end
        endcase
    end

    key_cycle_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr_s),
        .limit(limit_s),
        .done (done_s)
    );

    // Gesture FSM with registered pulse outputs; edge events beat timeouts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            click_r        <= 1'b0;
            double_click_r <= 1'b0;
            long_press_r   <= 1'b0;
            repeat_tick_r  <= 1'b0;
            held_r         <= 1'b0;
        end else begin
            click_r        <= 1'b0;
            double_click_r <= 1'b0;
            long_press_r   <= 1'b0;
            repeat_tick_r  <= 1'b0;
            held_r         <= (state_r == ST_PRESS1) || (state_r == ST_PRESS2) ||
                              (state_r == ST_LONG);
            case (state_r)
                ST_IDLE: begin
                    if (ev_dn_s) begin
                        state_r <= ST_PRESS1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PRESS1: begin
                    if (ev_up_s) begin
                        state_r <= ST_RELEASE1;
                    end else if (done_s) begin
                        state_r      <= ST_LONG;
                        long_press_r <= 1'b1;
                    end else begin
                        state_r <= ST_PRESS1;
                    end
                end
                ST_RELEASE1: begin
                    if (ev_dn_s) begin
                        state_r <= ST_PRESS2;
                    end else if (done_s) begin
                        state_r <= ST_IDLE;
                        click_r <= 1'b1;
                    end else begin
                        state_r <= ST_RELEASE1;
                    end
                end
                ST_PRESS2: begin
                    if (ev_up_s) begin
                        state_r        <= ST_IDLE;
                        double_click_r <= 1'b1;
                    end else if (done_s) begin
                        state_r      <= ST_LONG;
                        long_press_r <= 1'b1;
                    end else begin
                        state_r <= ST_PRESS2;
                    end
                end
                ST_LONG: begin
                    if (ev_up_s) begin
                        state_r <= ST_IDLE;
                    end else if (done_s) begin
                        state_r       <= ST_LONG;
                        repeat_tick_r <= 1'b1;
                    end else begin
                        state_r <= ST_LONG;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign click        = click_r;
    assign double_click = double_click_r;
    assign long_press   = long_press_r;
    assign repeat_tick  = repeat_tick_r;
    assign held         = held_r;

endmodule
